// File: rtl/zet_bus_arbiter_pkg.sv
// Shared encodings for the Zet Wishbone front-end: FSM states, byte-lane
// selects and the grant-index width helper.
package zet_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CYC1 = 2'd1,
        CYC2 = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_HI   = 2'b10;
    localparam logic [1:0] SEL_WORD = 2'b11;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zet_bus_rr_arbiter.sv
// NCH-way grant encoder: lowest index wins when RR=0, otherwise the first
// requester strictly after the last grant, with the pointer held here.
module zet_bus_rr_arbiter
    import zet_bus_arbiter_pkg::*;
#(
    parameter int NCH = 2,
    parameter int RR  = 0,
    localparam int IW = idx_w(NCH)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NCH-1:0] req_i,
    input  logic           en_i,
    output logic           any_o,
    output logic [IW-1:0]  gnt_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    assign any_o = |req_i;

    // Scan from the far end so the closest match overwrites earlier ones.
    always_comb begin
        gnt_o = '0;
        cand  = '0;
        if (RR == 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (req_i[i]) gnt_o = IW'(i);
            end
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                cand = IW'((int'(ptr_q) + k) % NCH);
                if (req_i[cand]) gnt_o = cand;
            end
        end
    end

    always_comb begin
        ptr_d = (en_i && any_o) ? gnt_o : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= IW'(NCH - 1);
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/zet_bus_arbiter.sv
// Multi-channel Wishbone master front-end: arbitrates requesters, steers byte
// lanes and splits unaligned word accesses into two bus cycles.
module zet_bus_arbiter
    import zet_bus_arbiter_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = 20,
    parameter int RR    = 0,
    parameter int SPLIT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH*AW-1:0] req_adr_i,
    input  logic [NCH*16-1:0] req_dat_i,
    input  logic [NCH-1:0]    req_we_i,
    input  logic [NCH-1:0]    req_byte_i,
    input  logic [NCH-1:0]    req_mio_i,
    input  logic [NCH-1:0]    req_stb_i,
    output logic [NCH-1:0]    req_ack_o,
    output logic [15:0]       req_dat_o,
    output logic [AW-2:0]     wb_adr_o,
    output logic [15:0]       wb_dat_o,
    input  logic [15:0]       wb_dat_i,
    output logic [1:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_tga_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    output logic [1:0]        dbg_state_o
);

    localparam int IW = idx_w(NCH);

    state_e         state_q, state_d;
    logic [IW-1:0]  gnt_q, gnt_d, gnt_c;
    logic [AW-1:0]  adr_q, adr_d;
    logic [7:0]     hi_q, hi_d, lo_q, lo_d;
    logic           byte_q, byte_d, split_q, split_d;
    logic [AW-2:0]  wb_adr_q, wb_adr_d;
    logic [15:0]    wb_dat_q, wb_dat_d;
    logic [1:0]     wb_sel_q, wb_sel_d;
    logic           wb_we_q, wb_we_d, wb_tga_q, wb_tga_d, wb_cyc_q, wb_cyc_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic [15:0]    rdat_q, rdat_d;
    logic           any_c;
    logic [AW-1:0]  c_adr;
    logic [15:0]    c_dat;
    logic           c_byte;

    zet_bus_rr_arbiter #(.NCH(NCH), .RR(RR)) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_stb_i),
        .en_i  (state_q == IDLE),
        .any_o (any_c),
        .gnt_o (gnt_c)
    );

    assign c_adr  = req_adr_i[int'(gnt_c)*AW +: AW];
    assign c_dat  = req_dat_i[int'(gnt_c)*16 +: 16];
    assign c_byte = req_byte_i[gnt_c];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            adr_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            byte_q   <= 1'b0;
            split_q  <= 1'b0;
            wb_adr_q <= '0;
            wb_dat_q <= '0;
            wb_sel_q <= '0;
            wb_we_q  <= 1'b0;
            wb_tga_q <= 1'b0;
            wb_cyc_q <= 1'b0;
            ack_q    <= '0;
            rdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            adr_q    <= adr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            byte_q   <= byte_d;
            split_q  <= split_d;
            wb_adr_q <= wb_adr_d;
            wb_dat_q <= wb_dat_d;
            wb_sel_q <= wb_sel_d;
            wb_we_q  <= wb_we_d;
            wb_tga_q <= wb_tga_d;
            wb_cyc_q <= wb_cyc_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_c) state_d = CYC1;
            CYC1:    if (wb_ack_i) state_d = split_q ? CYC2 : DONE;
            CYC2:    if (wb_ack_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = gnt_q;
        adr_d    = adr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        byte_d   = byte_q;
        split_d  = split_q;
        wb_adr_d = wb_adr_q;
        wb_dat_d = wb_dat_q;
        wb_sel_d = wb_sel_q;
        wb_we_d  = wb_we_q;
        wb_tga_d = wb_tga_q;
        wb_cyc_d = wb_cyc_q;
        ack_d    = '0;
        rdat_d   = rdat_q;
        case (state_q)
            IDLE: if (any_c) begin
                gnt_d    = gnt_c;
                adr_d    = c_adr;
                hi_d     = c_dat[15:8];
                byte_d   = c_byte;
                split_d  = (SPLIT != 0) && !c_byte && c_adr[0];
                wb_adr_d = c_adr[AW-1:1];
                wb_we_d  = req_we_i[gnt_c];
                wb_tga_d = req_mio_i[gnt_c];
                wb_cyc_d = 1'b1;
                if (c_byte) begin
                    wb_sel_d = c_adr[0] ? SEL_HI : SEL_LO;
                    wb_dat_d = {c_dat[7:0], c_dat[7:0]};
                end else if ((SPLIT != 0) && c_adr[0]) begin
                    wb_sel_d = SEL_HI;
                    wb_dat_d = {c_dat[7:0], 8'h00};
                end else begin
                    wb_sel_d = SEL_WORD;
                    wb_dat_d = c_dat;
                end
            end
            CYC1: if (wb_ack_i) begin
                if (split_q) begin
                    // Odd address: (a+1)>>1 is simply the next word, wrapping.
                    lo_d     = wb_dat_i[15:8];
                    wb_adr_d = adr_q[AW-1:1] + 1'b1;
                    wb_sel_d = SEL_LO;
                    wb_dat_d = {8'h00, hi_q};
                end else begin
                    wb_cyc_d = 1'b0;
                    ack_d    = NCH'(1) << gnt_q;
                    if (byte_q) rdat_d = {8'h00, adr_q[0] ? wb_dat_i[15:8] : wb_dat_i[7:0]};
                    else        rdat_d = wb_dat_i;
                end
            end
            CYC2: if (wb_ack_i) begin
                wb_cyc_d = 1'b0;
                ack_d    = NCH'(1) << gnt_q;
                rdat_d   = {wb_dat_i[7:0], lo_q};
            end
            default: ;
        endcase
    end

    assign req_ack_o   = ack_q;
    assign req_dat_o   = rdat_q;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_sel_o    = wb_sel_q;
    assign wb_we_o     = wb_we_q;
    assign wb_tga_o    = wb_tga_q;
    assign wb_cyc_o    = wb_cyc_q;
    assign wb_stb_o    = wb_cyc_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/zet_bus_arbiter.md
Name: zet_bus_arbiter

Overview:
- Parametrised Wishbone master front-end for the Zet core.
- Successor to the fixed two-way fetch/exec address mux in the CPU top. Arbitrates NCH requesters (fetch, exec, later a prefetch queue or DMA) onto one 16-bit Wishbone master port.
- Adds fixed-priority or round-robin arbitration, byte-lane steering, and automatic splitting of unaligned word accesses into two bus cycles.
- Sits between the fetch/exec units and the system bus.

Parameters:
- NCH, 2, number of requesting channels (1..8); channel 0 is highest priority in fixed mode.
- AW, 20, byte address width.
- RR, 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
- SPLIT, 1, 1 = split unaligned words into two cycles; 0 = force adr[0]=0 and issue one cycle.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- req_adr_i  in  NCH*AW  per-channel byte address; channel n in slice [n*AW +: AW].
- req_dat_i  in  NCH*16  per-channel write data.
- req_we_i  in  NCH  per-channel write enable.
- req_byte_i  in  NCH  per-channel byte access (1) or word access (0).
- req_mio_i  in  NCH  per-channel memory (1) or I/O (0) select.
- req_stb_i  in  NCH  per-channel request; held high until that channel's ack.
- req_ack_o  out  NCH  one-cycle completion pulse, one-hot.
- req_dat_o  out  16  read data, valid while any req_ack_o bit is high.
- wb_adr_o  out  AW-1  word address (byte address [AW-1:1]).
- wb_dat_o  out  16  write data, lane-steered.
- wb_dat_i  in  16  read data.
- wb_sel_o  out  2  byte lane selects: [0] = low byte, [1] = high byte.
- wb_we_o  out  1  write enable.
- wb_tga_o  out  1  mio tag.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  bus acknowledge.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state IDLE; all wb_* outputs 0; req_ack_o 0; req_dat_o 0; round-robin pointer NCH-1, so channel 0 wins first. Reset mid-cycle abandons the transfer and no ack is issued.
- States: IDLE, CYC1, CYC2, DONE. All outputs are registered.
- IDLE:
  - If any req_stb_i is high, latch the grant index g and the channel's adr/dat/we/byte/mio.
  - Drive wb_cyc_o = wb_stb_o = 1 with first-cycle address, lanes and data.
  - Go to CYC1.
- Grant rule:
  - RR=0: lowest asserted index.
  - RR=1: first asserted index strictly after the pointer, modulo NCH. The pointer updates to g on grant.
- CYC1 on wb_ack_i:
  - If the access is split, capture the first byte, drive second-cycle address and lanes, and go to CYC2. cyc and stb stay high.
  - Otherwise capture data, drop cyc and stb, pulse req_ack_o[g], and go to DONE.
- CYC2 on wb_ack_i: capture the second byte, drop cyc and stb, pulse req_ack_o[g], and go to DONE.
- DONE: one idle cycle that lets the requester drop stb, then go to IDLE. No grant is made in DONE.
- Latency: stb at cycle 0 gives wb_stb_o at cycle 1. With zero-wait ack, req_ack_o is at cycle 2 for an aligned access and cycle 3 for a split one.
- wb_ack_i outside CYC1/CYC2 is ignored.
- Lane rules, with a = latched address:
  - Byte access: wb_sel_o = a[0] ? 2'b10 : 2'b01. Write data req_dat_i[7:0] is replicated to both lanes. Read returns {8'h00, selected lane}.
  - Aligned word: wb_sel_o = 2'b11 and data passes straight through.
  - Unaligned word with SPLIT=1:
    - Cycle 1: word a>>1, sel 2'b10, low data byte on the high lane.
    - Cycle 2: word (a+1)>>1, sel 2'b01, high data byte on the low lane.
    - Read result = {cycle-2 low lane, cycle-1 high lane}.
    - a+1 wraps modulo 2^AW.
- A channel dropping stb mid-transfer does not abort the transfer; the ack is still issued.
- Simultaneous requests are resolved by the grant rule; the losers wait and are never dropped.

Decomposition:
- Shared package: state encoding constants (IDLE/CYC1/CYC2/DONE) and the lane-select constants.
- One sub-module, zet_bus_rr_arbiter: NCH-wide priority/round-robin grant encoder holding the pointer register.

Test Plan:
- Aligned word read, ch1, adr 20'h00104, wb_dat_i 16'hBEEF, ack on first stb cycle -> wb_adr_o = 19'h00082, sel 11; req_ack_o = 2'b10 at cycle 2; req_dat_o = BEEF.
- Unaligned word write, ch0, adr 20'h00201, data 16'h1234 -> cycle 1: adr 19'h00100, sel 10, dat 16'h34xx. Cycle 2: adr 19'h00101, sel 01, dat 16'hxx12. Single ack after the second wb ack.
- Byte read, adr 20'h00003, wb_dat_i 16'hA55A -> sel 10; req_dat_o = 16'h00A5.
- Both channels hold stb for 4 transactions, RR=1 -> grants 0,1,0,1. With RR=0 and ch0 always requesting -> ch0 only.
- Unaligned word read at 20'hFFFFF -> second cycle word address 19'h00000 (wrap).
- rst_i asserted while in CYC2 -> outputs go to 0 asynchronously, no req_ack_o. After reset the first grant is ch0.
